seq_shift_add_multiplier: RTL

Sequential shift-and-add unsigned multiplier that sits directly downstream of the dual-port-RAM controller. It consumes the controller's A, B and ena, and returns the product Y and done. Operands are valid only in the cycle ena first rises, so they are captured on that rising edge. Fixed, deterministic latency lets the controller's WAIT_OPERATION state simply poll done.

---
 rtl/mult_pkg.sv | 12 +
 rtl/seq_shift_add_multiplier.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and its controller.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_MULT_IDLE,
      ST_MULT_CALC,
      ST_MULT_DONE
   } mult_state_t;

   localparam int unsigned MULT_WIDTH = 4;

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with fixed WIDTH-cycle latency.
// Operands are captured on the start edge; done holds until ena is released.
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic               ena,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Y,
   output logic               done,
   output logic               busy
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned PW   = 2 * WIDTH;

   mult_state_t     state_q, state_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]   y_q, y_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic [PW-1:0]   acc_next;

   // Partial product for the current iteration; wraps modulo 2^PW.
   assign acc_next = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      done_d  = done_q;
      busy_d  = busy_q;

      case (state_q)
         ST_MULT_IDLE: begin
            done_d = 1'b0;
            busy_d = 1'b0;
            if (ena) begin
               mcand_d = {{WIDTH{1'b0}}, A};
               mplr_d  = B;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_MULT_CALC;
            end
         end

         ST_MULT_CALC: begin
            if (!ena) begin
               busy_d  = 1'b0;
               done_d  = 1'b0;
               state_d = ST_MULT_IDLE;
            end else begin
               acc_d   = acc_next;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               cnt_d   = cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  y_d     = acc_next;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_MULT_DONE;
               end
            end
         end

         ST_MULT_DONE: begin
            // Result stays put until the controller releases ena.
            if (!ena) begin
               done_d  = 1'b0;
               state_d = ST_MULT_IDLE;
            end
         end

         default: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_MULT_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q <= ST_MULT_IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign Y    = y_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
